// File: rtl/code_table_store.sv
// Code table store: captures {char, length, path} entries from the table builder
// and answers code-match queries by scanning entries in index order.
module code_table_store #(
   parameter int DEPTH  = 32,
   parameter int PATH_W = 12,
   parameter int LEN_W  = 4,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
   input  logic [7:0]        lookupTab,
   input  logic [LEN_W-1:0]  length,
   input  logic [PATH_W-1:0] path,
   output logic              saveComp,
   input  logic              clear,
   input  logic              query_req,
   input  logic [PATH_W-1:0] query_path,
   input  logic [LEN_W-1:0]  query_len,
   output logic              query_ack,
   output logic              query_hit,
   output logic [7:0]        query_char,
   output logic [CNT_W-1:0]  entry_count,
   output logic              full,
   output logic              overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RELEASE} wr_state_t;
   typedef enum logic [1:0] {Q_IDLE, Q_SCAN, Q_DONE} q_state_t;

   // Table storage; validity is tracked by count_reg, so the arrays are never reset.
   logic [7:0]        char_mem [DEPTH];
   logic [LEN_W-1:0]  len_mem  [DEPTH];
   logic [PATH_W-1:0] path_mem [DEPTH];

   wr_state_t         wr_state_reg, wr_state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              overflow_reg, overflow_next;
   logic              wr_en;

   q_state_t          q_state_reg, q_state_next;
   logic [PATH_W-1:0] q_path_reg, q_path_next;
   logic [LEN_W-1:0]  q_len_reg, q_len_next;
   logic [CNT_W-1:0]  scan_limit_reg, scan_limit_next;
   logic [CNT_W-1:0]  idx_reg, idx_next;
   logic              hit_reg, hit_next;
   logic [7:0]        char_reg, char_next;

   logic [7:0]        rd_char;
   logic [LEN_W-1:0]  rd_len;
   logic [PATH_W-1:0] rd_path;
   logic [PATH_W-1:0] len_mask;
   logic              entry_match;

   // ------------------------------------------------------------------
   // Storage write port
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en && !n_rst) begin
         char_mem[count_reg[AW-1:0]] <= lookupTab;
         len_mem[count_reg[AW-1:0]]  <= length;
         path_mem[count_reg[AW-1:0]] <= path;
      end
   end

   // ------------------------------------------------------------------
   // Write FSM: one table write per enable assertion
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (n_rst) begin
         wr_state_reg <= WR_IDLE;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_state_reg <= wr_state_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   always_comb begin
      wr_state_next = wr_state_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      wr_en         = 1'b0;
      case (wr_state_reg)
         WR_IDLE: begin
            if (enable) begin
               wr_state_next = WR_ACK;
               if (full) begin
                  overflow_next = 1'b1;
               end else if (length != '0) begin
                  wr_en      = 1'b1;
                  count_next = count_reg + ONE_CNT;
               end
            end
         end
         WR_ACK: begin
            wr_state_next = WR_RELEASE;
         end
         WR_RELEASE: begin
            if (!enable) wr_state_next = WR_IDLE;
         end
         default: begin
            wr_state_next = WR_IDLE;
         end
      endcase
      // A flush drops any pending write, including its saveComp pulse.
      if (clear) begin
         wr_state_next = WR_IDLE;
         count_next    = '0;
         overflow_next = 1'b0;
         wr_en         = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Match logic: compare only the low q_len bits of the path
   // ------------------------------------------------------------------
   assign rd_char = char_mem[idx_reg[AW-1:0]];
   assign rd_len  = len_mem[idx_reg[AW-1:0]];
   assign rd_path = path_mem[idx_reg[AW-1:0]];

   for (genvar gi = 0; gi < PATH_W; gi++) begin : g_mask
      assign len_mask[gi] = (32'(q_len_reg) > gi);
   end

   assign entry_match = (rd_len == q_len_reg) && (q_len_reg != '0) &&
                        (((rd_path ^ q_path_reg) & len_mask) == '0);

   // ------------------------------------------------------------------
   // Query FSM: linear scan over the entries present at request time
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (n_rst) begin
         q_state_reg    <= Q_IDLE;
         q_path_reg     <= '0;
         q_len_reg      <= '0;
         scan_limit_reg <= '0;
         idx_reg        <= '0;
         hit_reg        <= 1'b0;
         char_reg       <= '0;
      end else begin
         q_state_reg    <= q_state_next;
         q_path_reg     <= q_path_next;
         q_len_reg      <= q_len_next;
         scan_limit_reg <= scan_limit_next;
         idx_reg        <= idx_next;
         hit_reg        <= hit_next;
         char_reg       <= char_next;
      end
   end

   always_comb begin
      q_state_next    = q_state_reg;
      q_path_next     = q_path_reg;
      q_len_next      = q_len_reg;
      scan_limit_next = scan_limit_reg;
      idx_next        = idx_reg;
      hit_next        = hit_reg;
      char_next       = char_reg;
      case (q_state_reg)
         Q_IDLE: begin
            if (query_req) begin
               q_path_next     = query_path;
               q_len_next      = query_len;
               scan_limit_next = count_reg;
               idx_next        = '0;
               q_state_next    = Q_SCAN;
            end
         end
         Q_SCAN: begin
            if (scan_limit_reg == '0) begin
               hit_next     = 1'b0;
               char_next    = '0;
               q_state_next = Q_DONE;
            end else if (entry_match) begin
               hit_next     = 1'b1;
               char_next    = rd_char;
               q_state_next = Q_DONE;
            end else if (idx_reg == scan_limit_reg - ONE_CNT) begin
               hit_next     = 1'b0;
               char_next    = '0;
               q_state_next = Q_DONE;
            end else begin
               idx_next = idx_reg + ONE_CNT;
            end
         end
         Q_DONE: begin
            q_state_next = Q_IDLE;
         end
         default: begin
            q_state_next = Q_IDLE;
         end
      endcase
      // Flush aborts an in-flight scan silently and wipes the last result.
      if (clear) begin
         q_state_next = Q_IDLE;
         idx_next     = '0;
         hit_next     = 1'b0;
         char_next    = '0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign saveComp    = (wr_state_reg == WR_ACK);
   assign query_ack   = (q_state_reg == Q_DONE);
   assign query_hit   = hit_reg;
   assign query_char  = char_reg;
   assign entry_count = count_reg;
   assign full        = (count_reg == DEPTH_CNT);
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_code_table_store.sv
// Randomized self-checking bench for code_table_store against a simple
// list-based model of the code table.
module tb_code_table_store;
   localparam int DEPTH  = 32;
   localparam int PATH_W = 12;
   localparam int LEN_W  = 4;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              enable;
   logic [7:0]        lookupTab;
   logic [LEN_W-1:0]  length;
   logic [PATH_W-1:0] path;
   logic              saveComp;
   logic              clear;
   logic              query_req;
   logic [PATH_W-1:0] query_path;
   logic [LEN_W-1:0]  query_len;
   logic              query_ack;
   logic              query_hit;
   logic [7:0]        query_char;
   logic [CNT_W-1:0]  entry_count;
   logic              full;
   logic              overflow;

   code_table_store #(.DEPTH(DEPTH), .PATH_W(PATH_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .n_rst(n_rst), .enable(enable), .lookupTab(lookupTab),
      .length(length), .path(path), .saveComp(saveComp), .clear(clear),
      .query_req(query_req), .query_path(query_path), .query_len(query_len),
      .query_ack(query_ack), .query_hit(query_hit), .query_char(query_char),
      .entry_count(entry_count), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: list of stored entries in insertion order
   int  m_count;
   bit  m_ovf;
   int  m_char [DEPTH];
   int  m_len  [DEPTH];
   int  m_path [DEPTH];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      m_count = 0;
      m_ovf   = 0;
   endfunction

   function automatic void model_write(input int ch, input int ln, input int p);
      if (m_count == DEPTH) m_ovf = 1;
      else if (ln != 0) begin
         m_char[m_count] = ch;
         m_len[m_count]  = ln;
         m_path[m_count] = p;
         m_count++;
      end
   endfunction

   // Expected result and ack cycle (request issued in cycle 0)
   function automatic void model_query(input int qp, input int ql,
                                       output bit hit, output int ch, output int cyc);
      hit = 0;
      ch  = 0;
      cyc = ((m_count > 1) ? m_count : 1) + 1;
      if (ql != 0) begin
         for (int i = 0; i < m_count; i++) begin
            if (m_len[i] == ql && (((m_path[i] ^ qp) & ((1 << ql) - 1)) == 0)) begin
               hit = 1;
               ch  = m_char[i];
               cyc = i + 2;
               break;
            end
         end
      end
   endfunction

   // Drive one write, return cycle saveComp was seen (-1 if never)
   task automatic drive_write(input int ch, input int ln, input int p, output int sc_cyc);
      lookupTab = 8'(ch);
      length    = LEN_W'(ln);
      path      = PATH_W'(p);
      enable    = 1'b1;
      sc_cyc    = -1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (saveComp === 1'b1) begin
            sc_cyc = c;
            break;
         end
      end
      enable = 1'b0;
      tick();
      tick();
      model_write(ch, ln, p);
   endtask

   // Issue one query, return ack cycle (-1 if none) and result; ends in Q_IDLE
   task automatic run_query(input int qp, input int ql, output int ack_cyc,
                            output logic hit, output logic [7:0] ch);
      query_path = PATH_W'(qp);
      query_len  = LEN_W'(ql);
      query_req  = 1'b1;
      ack_cyc    = -1;
      hit        = 1'bx;
      ch         = 8'hxx;
      tick();
      query_req = 1'b0;
      for (int c = 1; c <= DEPTH + 4; c++) begin
         if (query_ack === 1'b1) begin
            ack_cyc = c;
            hit     = query_hit;
            ch      = query_char;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
   endtask

   task automatic check_query(input string name, input int qp, input int ql);
      int         cyc, e_cyc, e_ch;
      bit         e_hit;
      logic       hit;
      logic [7:0] ch;
      model_query(qp, ql, e_hit, e_ch, e_cyc);
      run_query(qp, ql, cyc, hit, ch);
      checks++;
      if (cyc != e_cyc || hit !== e_hit || ch !== 8'(e_ch)) begin
         errors++;
         $display("FAIL %s path=%03h len=%0d: got cyc=%0d hit=%b char=%02h, want cyc=%0d hit=%b char=%02h",
                  name, qp, ql, cyc, hit, ch, e_cyc, e_hit, e_ch[7:0]);
      end
      $display("query %s path=%03h len=%0d -> cyc=%0d hit=%b char=%02h", name, qp, ql, cyc, hit, ch);
   endtask

   task automatic test_reset();
      n_rst = 1'b1; enable = 0; clear = 0; query_req = 0;
      lookupTab = 0; length = 0; path = 0; query_path = 0; query_len = 0;
      tick(); tick(); tick();
      checks++;
      if ({saveComp, query_ack, query_hit, query_char, entry_count, full, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, want all zero",
                  {saveComp, query_ack, query_hit, query_char, entry_count, full, overflow});
      end
      n_rst = 1'b0;
      tick();
      model_clear();
      $display("reset done");
   endtask

   task automatic test_write_handshake();
      lookupTab = 8'h41; length = 4'd3; path = 12'h005; enable = 1'b1;
      tick();
      checks++;
      if (saveComp !== 1'b1 || entry_count !== 6'd1) begin
         errors++;
         $display("FAIL write_cycle1: got saveComp=%b count=%0d, want 1 1", saveComp, entry_count);
      end
      for (int c = 2; c <= 5; c++) begin
         tick();
         checks++;
         if (saveComp !== 1'b0 || entry_count !== 6'd1) begin
            errors++;
            $display("FAIL write_release c%0d: got saveComp=%b count=%0d, want 0 1", c, saveComp, entry_count);
         end
      end
      enable = 1'b0;
      tick(); tick();
      model_write(8'h41, 3, 12'h005);
      $display("write 41/3/005 with lingering enable -> count=%0d", entry_count);
   endtask

   task automatic test_query_basic();
      int sc;
      do_clear();
      drive_write(8'h41, 3, 12'h005, sc);
      checks++;
      if (sc != 1) begin errors++; $display("FAIL basic_wr0: saveComp cycle %0d, want 1", sc); end
      drive_write(8'h42, 2, 12'h002, sc);
      checks++;
      if (sc != 1) begin errors++; $display("FAIL basic_wr1: saveComp cycle %0d, want 1", sc); end
      check_query("hit_first", 12'hFF5, 3);
      checks++;
      if (query_hit !== 1'b1 || query_char !== 8'h41 || query_ack !== 1'b0) begin
         errors++;
         $display("FAIL hold_result: got hit=%b char=%02h ack=%b, want 1 41 0", query_hit, query_char, query_ack);
      end
      check_query("hit_second", 12'h002, 2);
      check_query("miss_two", 12'h001, 1);
      check_query("len_zero", 12'h005, 0);
      do_clear();
      check_query("empty", 12'h005, 3);
   endtask

   task automatic test_overflow();
      int sc;
      do_clear();
      for (int i = 0; i < DEPTH; i++) drive_write(i + 1, $urandom_range(1, 12), $urandom_range(0, 4095), sc);
      checks++;
      if (entry_count !== 6'(DEPTH) || full !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fill: got count=%0d full=%b ovf=%b, want %0d 1 0", entry_count, full, overflow, DEPTH);
      end
      drive_write(8'hEE, 5, 12'h01F, sc);
      checks++;
      if (sc != 1 || entry_count !== 6'(DEPTH) || full !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow: got sc=%0d count=%0d full=%b ovf=%b, want 1 %0d 1 1", sc, entry_count, full, overflow, DEPTH);
      end
      check_query("last_entry", m_path[DEPTH-1], m_len[DEPTH-1]);
      do_clear();
      checks++;
      if (entry_count !== '0 || full !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_after_full: got count=%0d full=%b ovf=%b, want 0 0 0", entry_count, full, overflow);
      end
      $display("overflow test done");
   endtask

   task automatic test_clear_during_scan();
      int sc, acks;
      do_clear();
      for (int i = 0; i < 20; i++) drive_write(8'h80 + i, 5, i, sc);
      check_query("pre_hit", 12'h003, 5);
      query_path = 12'h01F; query_len = 4'd5; query_req = 1'b1;
      tick();
      query_req = 1'b0;
      tick(); tick(); tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
      checks++;
      if (query_hit !== 1'b0 || query_char !== 8'h00 || entry_count !== '0) begin
         errors++;
         $display("FAIL clear_scan_result: got hit=%b char=%02h count=%0d, want 0 00 0", query_hit, query_char, entry_count);
      end
      acks = 0;
      for (int c = 0; c < 30; c++) begin
         if (query_ack === 1'b1) acks++;
         tick();
      end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL aborted_ack: got %0d acks, want 0", acks); end
      check_query("after_abort", 12'h003, 5);
   endtask

   task automatic test_clear_write_same_cycle();
      int sc_seen;
      lookupTab = 8'h55; length = 4'd4; path = 12'h00A;
      enable = 1'b1; clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
      checks++;
      if (saveComp !== 1'b0 || entry_count !== '0) begin
         errors++;
         $display("FAIL clear_wins: got saveComp=%b count=%0d, want 0 0", saveComp, entry_count);
      end
      tick();
      sc_seen = saveComp;
      checks++;
      if (sc_seen != 1 || entry_count !== 6'd1) begin
         errors++;
         $display("FAIL rewrite_after_clear: got saveComp=%0d count=%0d, want 1 1", sc_seen, entry_count);
      end
      enable = 1'b0;
      tick(); tick();
      model_write(8'h55, 4, 12'h00A);
      check_query("after_clear_write", 12'hF0A, 4);
   endtask

   task automatic test_back_to_back();
      int   sc, e_cyc, e_ch, first_cyc, acks;
      bit   e_hit;
      logic first_hit;
      do_clear();
      for (int i = 0; i < 10; i++) drive_write(8'h60 + i, 4, i, sc);
      model_query(12'h3AF, 4, e_hit, e_ch, e_cyc);
      query_path = 12'h3AF; query_len = 4'd4; query_req = 1'b1;
      first_cyc = -1; first_hit = 1'bx; acks = 0;
      for (int c = 1; c <= DEPTH + 4; c++) begin
         tick();
         if (c == 1) begin
            query_req = 1'b0;
            lookupTab = 8'h7E; length = 4'd4; path = 12'h00F; enable = 1'b1;
         end else if (c == 2) begin
            enable = 1'b0;
            query_path = 12'h00F; query_req = 1'b1;
         end else if (c == 3) begin
            query_req = 1'b0;
         end
         if (query_ack === 1'b1) begin
            acks++;
            if (first_cyc < 0) begin first_cyc = c; first_hit = query_hit; end
         end
      end
      model_write(8'h7E, 4, 12'h00F);
      checks++;
      if (first_cyc != e_cyc || first_hit !== e_hit || acks != 1) begin
         errors++;
         $display("FAIL inflight_query: got cyc=%0d hit=%b acks=%0d, want cyc=%0d hit=%b acks=1",
                  first_cyc, first_hit, acks, e_cyc, e_hit);
      end
      checks++;
      if (entry_count !== 6'(m_count)) begin
         errors++;
         $display("FAIL write_during_scan: got count=%0d, want %0d", entry_count, m_count);
      end
      check_query("new_entry", 12'h00F, 4);
   endtask

   task automatic test_random();
      int sc, k, ln, p, msk;
      do_clear();
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 99) < 3) do_clear();
         if ($urandom_range(0, 99) < 45) begin
            ln = $urandom_range(0, 5);
            drive_write($urandom_range(0, 255), ln, $urandom_range(0, 4095), sc);
            checks++;
            if (sc != 1 || entry_count !== 6'(m_count) || overflow !== m_ovf || full !== (m_count == DEPTH)) begin
               errors++;
               $display("FAIL rand_write it%0d: got sc=%0d count=%0d ovf=%b full=%b, want 1 %0d %b %b",
                        it, sc, entry_count, overflow, full, m_count, m_ovf, m_count == DEPTH);
            end
         end else if (m_count > 0 && $urandom_range(0, 99) < 70) begin
            k   = $urandom_range(0, m_count - 1);
            ln  = m_len[k];
            msk = (1 << ln) - 1;
            p   = (m_path[k] & msk) | ($urandom_range(0, 4095) & ~msk & 12'hFFF);
            check_query("rand_stored", p, ln);
         end else begin
            check_query("rand_any", $urandom_range(0, 4095), $urandom_range(0, 6));
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_handshake();
      test_query_basic();
      test_overflow();
      test_clear_during_scan();
      test_clear_write_same_cycle();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
